usb_token_sched: RTL and testbench

Host-side USB token/SOF packet scheduler. It shares one combinational CRC5 generator between two requesters: the host token request port (OUT/IN/SETUP/PING) and a start-of-frame (SOF) generator with its own 11-bit frame counter. It emits each 3-byte packet (PID, payload low byte, payload high bits plus CRC5) on a byte stream with a valid/ready handshake. The byte stream feeds the downstream USB serializer/NRZI stage.

---
 rtl/usb_pkg.sv | 25 ++
 rtl/usb_crc5_11_inv.sv | 23 ++
 rtl/usb_token_sched.sv | 107 ++++++++++
 tb/tb_usb_token_sched.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - PID codes, scheduler state encoding and bit helpers for the USB token scheduler
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_PING  = 4'h4;
  localparam logic [3:0] PID_SOF   = 4'h5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B0   = 2'd1,
    ST_B1   = 2'd2,
    ST_B2   = 2'd3
  } state_t;

  function automatic logic [4:0] rev5(input logic [4:0] x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic pid_legal(input logic [3:0] p);
    return (p == PID_OUT) || (p == PID_IN) || (p == PID_SETUP) || (p == PID_PING);
  endfunction

endpackage

// File: rtl/usb_crc5_11_inv.sv
// rtl/usb_crc5_11_inv.sv - combinational CRC5 (x^5+x^2+1, preset ones) over 11 bits, LSB first
// Output is the inverted remainder in bit-reversed order.
module usb_crc5_11_inv
  import usb_pkg::*;
(
  input  logic [10:0] d,
  output logic [4:0]  c
);

  logic [4:0] r;
  logic       fb;

  always_comb begin
    r  = 5'h1F;
    fb = 1'b0;
    for (int i = 0; i < 11; i++) begin
      fb = d[i] ^ r[4];
      r  = {r[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    c = rev5(~r);
  end

endmodule

// File: rtl/usb_token_sched.sv
// rtl/usb_token_sched.sv - host USB token/SOF packet scheduler sharing one CRC5 generator
module usb_token_sched
  import usb_pkg::*;
#(
  parameter bit          PID_CHECK  = 1'b1,
  parameter logic [10:0] FRAME_INIT = 11'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sof_en,
  input  logic        sof_tick,
  input  logic        tok_valid,
  output logic        tok_ready,
  input  logic [3:0]  tok_pid,
  input  logic [6:0]  tok_addr,
  input  logic [3:0]  tok_endp,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [10:0] frame_no,
  output logic        sof_miss,
  output logic        tok_err
);

  state_t      state;
  logic [10:0] d_q;
  logic        is_sof;
  logic        sof_pending;
  logic        sof_req;
  logic [4:0]  crc;

  assign sof_req   = sof_tick & sof_en;
  assign tok_ready = (state == ST_IDLE) & ~sof_pending & ~sof_req & ~rst;

  usb_crc5_11_inv u_crc (
    .d (d_q),
    .c (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      d_q         <= '0;
      is_sof      <= 1'b0;
      sof_pending <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      frame_no    <= FRAME_INIT;
      sof_miss    <= 1'b0;
      tok_err     <= 1'b0;
    end else begin
      tok_err  <= 1'b0;
      // A tick landing on an already queued SOF is merged into it.
      sof_miss <= sof_req & sof_pending;
      if (sof_req) sof_pending <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (sof_pending || sof_req) begin
            d_q         <= frame_no;
            is_sof      <= 1'b1;
            sof_pending <= 1'b0;
            m_valid     <= 1'b1;
            m_data      <= {~PID_SOF, PID_SOF};
            state       <= ST_B0;
          end else if (tok_valid) begin
            if (PID_CHECK && !pid_legal(tok_pid)) begin
              tok_err <= 1'b1;
            end else begin
              d_q     <= {tok_endp, tok_addr};
              is_sof  <= 1'b0;
              m_valid <= 1'b1;
              m_data  <= {~tok_pid, tok_pid};
              state   <= ST_B0;
            end
          end
        end
        ST_B0: begin
          if (m_ready) begin
            m_data <= d_q[7:0];
            state  <= ST_B1;
          end
        end
        ST_B1: begin
          if (m_ready) begin
            m_data <= {rev5(crc), d_q[10:8]};
            m_last <= 1'b1;
            state  <= ST_B2;
          end
        end
        ST_B2: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_data  <= '0;
            state   <= ST_IDLE;
            if (is_sof) frame_no <= frame_no + 11'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_token_sched.sv
// tb/tb_usb_token_sched.sv - self-checking bench for usb_token_sched with a byte-level reference model
module tb_usb_token_sched;

  logic        clk, rst, sof_en, sof_tick, tok_valid, m_ready;
  logic [3:0]  tok_pid, tok_endp;
  logic [6:0]  tok_addr;
  logic        tok_ready, m_valid, m_last, sof_miss, tok_err;
  logic [7:0]  m_data;
  logic [10:0] frame_no;
  logic        w_tok_ready, w_m_valid, w_m_last, w_sof_miss, w_tok_err;
  logic [7:0]  w_m_data;
  logic [10:0] w_frame_no;

  int          checks = 0;
  int          errors = 0;
  int          miss_cnt = 0;
  bit          rand_ready = 0;
  logic [7:0]  got_data[$];
  logic        got_last[$];
  logic [7:0]  exp_data[$];
  logic [10:0] exp_frame;
  logic [3:0]  legal_pids[4] = '{4'h1, 4'h9, 4'hD, 4'h4};

  usb_token_sched u_dut (
    .clk(clk), .rst(rst), .sof_en(sof_en), .sof_tick(sof_tick),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_pid(tok_pid),
    .tok_addr(tok_addr), .tok_endp(tok_endp), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .frame_no(frame_no), .sof_miss(sof_miss), .tok_err(tok_err)
  );

  usb_token_sched #(.FRAME_INIT(11'h7FF)) u_wrap (
    .clk(clk), .rst(rst), .sof_en(sof_en), .sof_tick(sof_tick),
    .tok_valid(tok_valid), .tok_ready(w_tok_ready), .tok_pid(tok_pid),
    .tok_addr(tok_addr), .tok_endp(tok_endp), .m_valid(w_m_valid),
    .m_ready(m_ready), .m_data(w_m_data), .m_last(w_m_last),
    .frame_no(w_frame_no), .sof_miss(w_sof_miss), .tok_err(w_tok_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // CRC5 as polynomial long division; the all-ones preset equals inverting the first five bits.
  function automatic logic [4:0] crc_rem(input logic [10:0] d);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 11; i++) v[15-i] = d[i] ^ (i < 5);
    for (int k = 15; k >= 5; k--)
      if (v[k]) v = v ^ (16'h0025 << (k - 5));
    return v[4:0];
  endfunction

  function automatic logic [7:0] byte2_of(input logic [10:0] d);
    return {~crc_rem(d), d[10:8]};
  endfunction

  task automatic push_exp(input logic [3:0] pid, input logic [10:0] d);
    exp_data.push_back({~pid, pid});
    exp_data.push_back(d[7:0]);
    exp_data.push_back(byte2_of(d));
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    got_data.delete();
    got_last.delete();
    exp_data.delete();
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int b = 0; b < budget; b++) begin
      if (got_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_ready) m_ready = ($urandom_range(0, 1) == 1);
  end

  logic       stall_prev = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  always @(negedge clk) begin
    if (stall_prev) begin
      checks++;
      if (m_valid !== 1'b1 || m_data !== stall_data || m_last !== stall_last) begin
        errors++;
        $display("FAIL hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                 m_valid, m_data, m_last, stall_data, stall_last);
      end
    end
    if (!rst && m_valid && m_ready) begin
      got_data.push_back(m_data);
      got_last.push_back(m_last);
    end
    if (!rst && sof_miss) miss_cnt++;
    stall_prev = !rst && m_valid && !m_ready;
    stall_data = m_data;
    stall_last = m_last;
  end

  task automatic compare_stream(input string tag);
    checks++;
    if (got_data.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL %s count: got %0d bytes, required %0d", tag, got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        checks++;
        if (got_data[i] !== exp_data[i] || got_last[i] !== (i % 3 == 2)) begin
          errors++;
          $display("FAIL %s byte %0d: got %h last=%b, required %h last=%b",
                   tag, i, got_data[i], got_last[i], exp_data[i], (i % 3 == 2));
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sof_en = 1'b0; sof_tick = 1'b0; tok_valid = 1'b1;
    tok_pid = 4'h1; tok_addr = '0; tok_endp = '0; m_ready = 1'b1;
    repeat (2) cyc();
    checks++;
    if (tok_ready !== 1'b0 || w_tok_ready !== 1'b0) begin
      errors++; $display("FAIL reset tok_ready: got %b/%b, required 0", tok_ready, w_tok_ready);
    end
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || w_m_valid !== 1'b0 || w_m_last !== 1'b0) begin
      errors++; $display("FAIL reset stream: valid=%b data=%h last=%b, required 0/00/0", m_valid, m_data, m_last);
    end
    checks++;
    if (frame_no !== 11'h000 || w_frame_no !== 11'h7FF) begin
      errors++; $display("FAIL reset frame_no: got %h/%h, required 000/7ff", frame_no, w_frame_no);
    end
    checks++;
    if (sof_miss !== 1'b0 || tok_err !== 1'b0 || w_sof_miss !== 1'b0 || w_tok_err !== 1'b0) begin
      errors++; $display("FAIL reset pulses: sof_miss=%b tok_err=%b, required 0", sof_miss, tok_err);
    end
    tok_valid = 1'b0;
    rst = 1'b0;
    cyc();
    checks++;
    if (tok_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL idle after reset: tok_ready=%b m_valid=%b, required 1/0", tok_ready, m_valid);
    end
    exp_frame = 11'h000;
    clear_q();
  endtask

  task automatic test_out_token();
    clear_q();
    m_ready = 1'b1;
    tok_pid = 4'h1; tok_addr = 7'h15; tok_endp = 4'hE; tok_valid = 1'b1;
    #1;
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++; $display("FAIL out tok_ready idle: got %b, required 1", tok_ready);
    end
    cyc();
    tok_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (tok_ready !== 1'b0 || m_valid !== 1'b1 || m_last !== (i == 2)) begin
        errors++; $display("FAIL out byte %0d flags: tok_ready=%b valid=%b last=%b", i, tok_ready, m_valid, m_last);
      end
      cyc();
    end
    checks++;
    if (tok_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL out return idle: tok_ready=%b valid=%b, required 1/0", tok_ready, m_valid);
    end
    exp_data = '{8'hE1, 8'h15, 8'hBF};
    compare_stream("out_token");
  endtask

  task automatic test_sof();
    logic [7:0] wexp[3];
    clear_q();
    sof_en = 1'b1; m_ready = 1'b1;
    wexp = '{8'hA5, 8'hFF, byte2_of(11'h7FF)};
    checks++;
    if (frame_no !== exp_frame || w_frame_no !== 11'h7FF) begin
      errors++; $display("FAIL sof start frame: got %h/%h, required %h/7ff", frame_no, w_frame_no, exp_frame);
    end
    sof_tick = 1'b1;
    cyc();
    sof_tick = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (w_m_valid !== 1'b1 || w_m_data !== wexp[i]) begin
        errors++; $display("FAIL sof wrap byte %0d: got %h, required %h", i, w_m_data, wexp[i]);
      end
      if (i == 2) begin
        checks++;
        if (frame_no !== 11'h000) begin
          errors++; $display("FAIL sof early increment: got %h, required 000", frame_no);
        end
      end
      cyc();
    end
    checks++;
    if (frame_no !== 11'h001 || w_frame_no !== 11'h000) begin
      errors++; $display("FAIL sof increment: got %h/%h, required 001/000", frame_no, w_frame_no);
    end
    exp_data = '{8'hA5, 8'h00, 8'h40};
    compare_stream("sof");
    exp_frame = 11'h001;
  endtask

  task automatic test_priority();
    int         hs_at;
    bit         ok;
    logic [10:0] d;
    clear_q();
    m_ready = 1'b1;
    tok_pid = 4'h9; tok_addr = 7'($urandom_range(0, 127)); tok_endp = 4'($urandom_range(0, 15));
    d = {tok_endp, tok_addr};
    sof_tick = 1'b1; tok_valid = 1'b1;
    #1;
    checks++;
    if (tok_ready !== 1'b0) begin
      errors++; $display("FAIL prio tok_ready: got %b, required 0", tok_ready);
    end
    hs_at = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (hs_at < 0 && tok_valid && tok_ready) hs_at = k;
      cyc();
      sof_tick = 1'b0;
      if (hs_at > 0) tok_valid = 1'b0;
    end
    tok_valid = 1'b0;
    checks++;
    if (hs_at !== 5) begin
      errors++; $display("FAIL prio token accept cycle: got %0d, required 5", hs_at);
    end
    push_exp(4'h5, exp_frame);
    push_exp(4'h9, d);
    exp_frame = exp_frame + 11'd1;
    wait_bytes(6, 40, ok);
    compare_stream("priority");
  endtask

  task automatic test_back_to_back();
    bit ok, done;
    logic [3:0] pid;
    clear_q();
    sof_en = 1'b1;
    rand_ready = 1'b1;
    for (int p = 0; p < 20; p++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 200 && got_data.size() < exp_data.size(); b++) cyc();
        sof_tick = 1'b1;
        cyc();
        sof_tick = 1'b0;
        push_exp(4'h5, exp_frame);
        exp_frame = exp_frame + 11'd1;
      end else begin
        pid = legal_pids[$urandom_range(0, 3)];
        tok_pid = pid; tok_addr = 7'($urandom_range(0, 127)); tok_endp = 4'($urandom_range(0, 15));
        tok_valid = 1'b1;
        done = 1'b0;
        for (int b = 0; b < 200 && !done; b++) begin
          if (tok_ready) done = 1'b1;
          cyc();
        end
        tok_valid = 1'b0;
        checks++;
        if (!done) begin
          errors++; $display("FAIL b2b token %0d accept: got timeout, required handshake", p);
        end
        push_exp(pid, {tok_endp, tok_addr});
      end
    end
    wait_bytes(exp_data.size(), 2000, ok);
    rand_ready = 1'b0;
    cyc();
    m_ready = 1'b1;
    compare_stream("back_to_back");
    checks++;
    if (frame_no !== exp_frame) begin
      errors++; $display("FAIL b2b frame_no: got %h, required %h", frame_no, exp_frame);
    end
  endtask

  task automatic test_sof_miss();
    clear_q();
    m_ready = 1'b1; sof_en = 1'b1; miss_cnt = 0;
    sof_tick = 1'b1;
    repeat (3) cyc();
    sof_tick = 1'b0;
    push_exp(4'h5, exp_frame);
    push_exp(4'h5, exp_frame + 11'd1);
    exp_frame = exp_frame + 11'd2;
    repeat (8) cyc();
    compare_stream("sof_miss");
    checks++;
    if (miss_cnt !== 1) begin
      errors++; $display("FAIL sof_miss pulses: got %0d, required 1", miss_cnt);
    end
    checks++;
    if (frame_no !== exp_frame) begin
      errors++; $display("FAIL sof_miss frame_no: got %h, required %h", frame_no, exp_frame);
    end
    clear_q();
    miss_cnt = 0;
    sof_en = 1'b0;
    repeat (3) begin
      sof_tick = 1'b1; cyc();
      sof_tick = 1'b0; cyc();
    end
    repeat (4) cyc();
    checks++;
    if (got_data.size() !== 0 || miss_cnt !== 0 || frame_no !== exp_frame) begin
      errors++; $display("FAIL sof disabled: bytes=%0d miss=%0d frame=%h, required 0/0/%h",
                         got_data.size(), miss_cnt, frame_no, exp_frame);
    end
  endtask

  task automatic test_bad_pid_reset();
    logic [10:0] d;
    clear_q();
    m_ready = 1'b1;
    tok_pid = 4'h3; tok_addr = 7'h2A; tok_endp = 4'h1; tok_valid = 1'b1;
    #1;
    checks++;
    if (tok_ready !== 1'b1) begin
      errors++; $display("FAIL bad pid consumed: tok_ready=%b, required 1", tok_ready);
    end
    cyc();
    tok_valid = 1'b0;
    checks++;
    if (tok_err !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL bad pid pulse: tok_err=%b valid=%b, required 1/0", tok_err, m_valid);
    end
    cyc();
    checks++;
    if (tok_err !== 1'b0 || m_valid !== 1'b0 || tok_ready !== 1'b1) begin
      errors++; $display("FAIL bad pid after: tok_err=%b valid=%b ready=%b, required 0/0/1", tok_err, m_valid, tok_ready);
    end
    tok_pid = 4'hD; tok_addr = 7'($urandom_range(0, 127)); tok_endp = 4'($urandom_range(0, 15));
    d = {tok_endp, tok_addr};
    tok_valid = 1'b1;
    cyc();
    tok_valid = 1'b0;
    cyc();
    checks++;
    if (m_data !== d[7:0]) begin
      errors++; $display("FAIL reset setup byte1: got %h, required %h", m_data, d[7:0]);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || frame_no !== 11'h000 || w_frame_no !== 11'h7FF) begin
      errors++; $display("FAIL mid-packet reset: valid=%b data=%h last=%b frame=%h/%h", m_valid, m_data, m_last, frame_no, w_frame_no);
    end
    rst = 1'b0;
    exp_frame = 11'h000;
    cyc();
    clear_q();
    tok_pid = 4'h4; tok_valid = 1'b1;
    cyc();
    tok_valid = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_data !== 8'hB4) begin
      errors++; $display("FAIL restart B0: valid=%b data=%h, required 1/b4", m_valid, m_data);
    end
    push_exp(4'h4, d);
    repeat (3) cyc();
    compare_stream("restart");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_out_token();
    test_sof();
    test_priority();
    test_back_to_back();
    test_sof_miss();
    test_bad_pid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
